l2_inmem: RTL and testbench
===========================

L2_INMEM -- requirements
Module: l2_inmem

Interface
REQ-001 Parameter DATA_SIZE, default 64, width of one stored activation word.
REQ-002 Parameter NUM_INPUT, default 16, number of layer-2 input channels.
REQ-003 Parameter INPUT_DIM, default 26, row and column extent of each channel plane.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 wantwrite  input  1  write request from the layer-1/layer-2 scheduler.
REQ-007 wr_col, wr_row, wr_ch  input  16 each  write coordinates (column, row, channel).
REQ-008 wr_data  input  DATA_SIZE  write word.
REQ-009 wr_ack  output  1  one-cycle pulse, write accepted.
REQ-010 clear  input  1  discard contents and return to EMPTY for the next image.
REQ-011 rd_req  input  1  read request from the layer-2 compute engine.
REQ-012 rd_col, rd_row, rd_ch  input  16 each  read coordinates.
REQ-013 rd_data  output  DATA_SIZE  read word.
REQ-014 rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-015 full  output  1  all NUM_INPUT*INPUT_DIM*INPUT_DIM words written.
REQ-016 idx_err  output  1  sticky flag, out-of-range coordinate seen.

Function
REQ-017 Address SHALL be ch*INPUT_DIM*INPUT_DIM + row*INPUT_DIM + col, width clog2(NUM_INPUT*INPUT_DIM*INPUT_DIM) (14 bits at defaults), computed without truncation before range check.
REQ-018 States SHALL be EMPTY, FILLING, FULL.
REQ-019 EMPTY -> FILLING on first accepted write; FILLING -> FULL when write count reaches NUM_INPUT*INPUT_DIM*INPUT_DIM (10816 at defaults); FULL -> EMPTY on clear; any state -> EMPTY on clear.
REQ-020 Write accepted only in EMPTY or FILLING, all coordinates in range, clear low; memory updated and wr_ack pulsed the cycle after wantwrite is sampled high.
REQ-021 Write count increments by one per accepted write; rewriting an address still counts (scheduler contract: each address written once).
REQ-022 wantwrite in FULL SHALL be ignored: no memory change, no wr_ack, no idx_err.
REQ-023 Any out-of-range coordinate (col or row >= INPUT_DIM, ch >= NUM_INPUT) on wantwrite or rd_req SHALL drop the request and set idx_err until reset or clear.
REQ-024 Read served only in FULL with in-range coordinates: rd_data and rd_valid registered, latency exactly one cycle; one read per cycle sustained.
REQ-025 rd_req outside FULL SHALL produce no rd_valid; rd_data holds last value.
REQ-026 full SHALL be high exactly in state FULL, asserted the cycle after the final write is sampled.
REQ-027 clear and wantwrite in same cycle: clear wins, write dropped, count zeroed.
REQ-028 clear and rd_req in same cycle: read dropped, no rd_valid.
REQ-029 Simultaneous wantwrite and rd_req in FILLING: write served, read dropped.
REQ-030 Memory contents are not cleared by clear or reset; only the count and state return to zero/EMPTY.

Reset
REQ-031 On reset: state EMPTY, count 0, wr_ack 0, rd_valid 0, rd_data 0, full 0, idx_err 0.
REQ-032 Reset mid-fill SHALL abandon the fill; subsequent writes restart from count 0.

Structure
REQ-033 Shared package holds DATA_SIZE, l2_NUM_INPUT, l2_INPUT_DIM defaults and the state encoding enum.
REQ-034 One sub-module, l2_inmem_ram: single-port-write, single-port-read synchronous RAM with registered output; address/range logic and FSM stay in l2_inmem.

Verification
REQ-035 Reset, then 10816 writes in scheduler order (col fastest, ch slowest) with data = address -> wr_ack each cycle; full rises the cycle after write (col 25, row 25, ch 15).
REQ-036 After fill, read (col 3, row 7, ch 5) -> rd_valid next cycle, rd_data = 3565; back-to-back reads of addresses 0 and 10815 -> two consecutive rd_valid with data 0, 10815.
REQ-037 Write at (col 26, row 0, ch 0) -> no wr_ack, idx_err stays 1 until clear; count unchanged.
REQ-038 Fill 500 words, assert clear together with wantwrite -> no wr_ack, state EMPTY, full 0; a full 10816-write refill then sets full.
REQ-039 In FULL, pulse wantwrite at (0,0,0) data 0xFFFF -> no wr_ack; read (0,0,0) returns original 0.
REQ-040 rd_req while FILLING at count 100 -> no rd_valid; reset at count 5000 -> full never asserted until 10816 further writes.

Source files
------------

// File: rtl/l2_inmem_pkg.sv
// Shared defaults, FSM encoding and address helpers for the layer-2 input buffer.
package l2_inmem_pkg;
  localparam int DATA_SIZE    = 64;
  localparam int l2_NUM_INPUT = 16;
  localparam int l2_INPUT_DIM = 26;

  typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2} state_t;

  // Full-width flat address; 34 bits holds the worst case of 16-bit coordinates.
  function automatic logic [33:0] flat_addr(input logic [15:0] col, row, ch, input int dim);
    return 34'(ch) * 34'(dim * dim) + 34'(row) * 34'(dim) + 34'(col);
  endfunction

  function automatic logic in_range(input logic [15:0] col, row, ch, input int dim, input int nch);
    return (32'(col) < dim) && (32'(row) < dim) && (32'(ch) < nch);
  endfunction
endpackage

// File: rtl/l2_inmem_if.sv
// Scheduler write port and compute-engine read port of the layer-2 input buffer.
interface l2_inmem_if
  import l2_inmem_pkg::*;
#(parameter int DW = DATA_SIZE);
  logic          wantwrite;
  logic [15:0]   wr_col, wr_row, wr_ch;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic          clear;
  logic          rd_req;
  logic [15:0]   rd_col, rd_row, rd_ch;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          idx_err;

  modport master (
    output wantwrite, wr_col, wr_row, wr_ch, wr_data, clear, rd_req, rd_col, rd_row, rd_ch,
    input  wr_ack, rd_data, rd_valid, full, idx_err
  );
  modport slave (
    input  wantwrite, wr_col, wr_row, wr_ch, wr_data, clear, rd_req, rd_col, rd_row, rd_ch,
    output wr_ack, rd_data, rd_valid, full, idx_err
  );
endinterface

// File: rtl/l2_inmem_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
module l2_inmem_ram #(
  parameter int DW    = 64,
  parameter int DEPTH = 10816,
  parameter int AW    = $clog2(DEPTH)
)(
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Array itself is never reset; only the output register is.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk)
    if (reset)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/l2_inmem.sv
// Layer-2 input activation buffer: fills once per image, then serves reads.
module l2_inmem #(
  parameter int DATA_SIZE = l2_inmem_pkg::DATA_SIZE,
  parameter int NUM_INPUT = l2_inmem_pkg::l2_NUM_INPUT,
  parameter int INPUT_DIM = l2_inmem_pkg::l2_INPUT_DIM
)(
  input logic        clk,
  input logic        reset,
  l2_inmem_if.slave  bus
);
  import l2_inmem_pkg::*;

  localparam int TOTAL = NUM_INPUT * INPUT_DIM * INPUT_DIM;
  localparam int AW    = $clog2(TOTAL);
  localparam int CW    = $clog2(TOTAL + 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [33:0]   wr_flat, rd_flat;
  logic          wr_oob, rd_oob, wr_seen, rd_seen, last_wr;
  logic          wr_ok, rd_ok, full_c;
  logic          wr_ack_q, rd_valid_q, idx_err_q;

  assign wr_flat = flat_addr(bus.wr_col, bus.wr_row, bus.wr_ch, INPUT_DIM);
  assign rd_flat = flat_addr(bus.rd_col, bus.rd_row, bus.rd_ch, INPUT_DIM);
  assign wr_oob  = !in_range(bus.wr_col, bus.wr_row, bus.wr_ch, INPUT_DIM, NUM_INPUT)
                   || (wr_flat >= 34'(TOTAL));
  assign rd_oob  = !in_range(bus.rd_col, bus.rd_row, bus.rd_ch, INPUT_DIM, NUM_INPUT)
                   || (rd_flat >= 34'(TOTAL));

  // clear overrides everything; writes in FULL are invisible, even for idx_err.
  assign wr_seen = bus.wantwrite && !bus.clear && (state != FULL);
  assign rd_seen = bus.rd_req && !bus.clear;
  assign last_wr = (cnt == CW'(TOTAL - 1));

  always_ff @(posedge clk)
    if (reset) state <= EMPTY;
    else       state <= state_nx;

  always_comb begin
    state_nx = state;
    if (bus.clear) state_nx = EMPTY;
    else case (state)
      EMPTY:   if (wr_ok) state_nx = last_wr ? FULL : FILLING;
      FILLING: if (wr_ok && last_wr) state_nx = FULL;
      default: ;
    endcase
  end

  always_comb begin
    wr_ok  = 1'b0;
    rd_ok  = 1'b0;
    full_c = 1'b0;
    case (state)
      EMPTY, FILLING: wr_ok = wr_seen && !wr_oob;
      FULL: begin
        rd_ok  = rd_seen && !rd_oob;
        full_c = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk)
    if (reset) begin
      cnt        <= '0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      idx_err_q  <= 1'b0;
    end else begin
      wr_ack_q   <= wr_ok;
      rd_valid_q <= rd_ok;
      if (bus.clear) begin
        cnt       <= '0;
        idx_err_q <= 1'b0;
      end else begin
        if (wr_ok) cnt <= cnt + CW'(1);
        if ((wr_seen && wr_oob) || (rd_seen && rd_oob)) idx_err_q <= 1'b1;
      end
    end

  assign bus.wr_ack   = wr_ack_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.idx_err  = idx_err_q;
  assign bus.full     = full_c;

  l2_inmem_ram #(.DW(DATA_SIZE), .DEPTH(TOTAL), .AW(AW)) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (wr_ok),
    .waddr (wr_flat[AW-1:0]),
    .wdata (bus.wr_data),
    .re    (rd_ok),
    .raddr (rd_flat[AW-1:0]),
    .rdata (bus.rd_data)
  );
endmodule

// File: tb/tb_l2_inmem.sv
// Scenario bench for l2_inmem; read data checked through an expected-value queue.
module tb_l2_inmem;
  localparam int DIM   = 26;
  localparam int NCH   = 16;
  localparam int TOTAL = NCH * DIM * DIM;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l2_inmem_if #(.DW(64)) bus();

  l2_inmem #(.DATA_SIZE(64), .NUM_INPUT(NCH), .INPUT_DIM(DIM)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          vecs = 0;
  int          errs = 0;
  logic [63:0] exp_q [$];
  logic [63:0] mon_exp;

  // Every rd_valid pulse must match the oldest outstanding expected read.
  always @(negedge clk)
    if (bus.rd_valid === 1'b1) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL rd_spurious: rd_valid=1 rd_data=%0d, required no read outstanding", bus.rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.rd_data !== mon_exp) begin
          errs++;
          $display("FAIL rd_data: got %0d, required %0d", bus.rd_data, mon_exp);
        end
      end
    end

  function automatic int addr_of(int col, int row, int ch);
    return ch * DIM * DIM + row * DIM + col;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wantwrite = 1'b0;
    bus.rd_req    = 1'b0;
    bus.clear     = 1'b0;
  endtask

  task automatic chk(string nm, logic [63:0] got, logic [63:0] req);
    vecs++;
    if (got !== req) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h", nm, got, req);
    end
  endtask

  // Leaves wantwrite asserted; callers idle() when the burst ends.
  task automatic wr(int col, int row, int ch, logic [63:0] d, logic exp_ack, string nm);
    bus.wantwrite = 1'b1;
    bus.wr_col    = 16'(col);
    bus.wr_row    = 16'(row);
    bus.wr_ch     = 16'(ch);
    bus.wr_data   = d;
    cyc();
    vecs++;
    if (bus.wr_ack !== exp_ack) begin
      errs++;
      $display("FAIL %s: wr_ack got %b, required %b", nm, bus.wr_ack, exp_ack);
    end
  endtask

  task automatic rd(int col, int row, int ch, logic exp_vld, string nm);
    bus.rd_req = 1'b1;
    bus.rd_col = 16'(col);
    bus.rd_row = 16'(row);
    bus.rd_ch  = 16'(ch);
    if (exp_vld) exp_q.push_back(64'(addr_of(col, row, ch)));
    cyc();
    vecs++;
    if (bus.rd_valid !== exp_vld) begin
      errs++;
      $display("FAIL %s: rd_valid got %b, required %b", nm, bus.rd_valid, exp_vld);
    end
  endtask

  // Scheduler-order fill from count 0 with data = address.
  task automatic fill(int n, int rd_at, int oob_at);
    int col, row, ch;
    for (int k = 0; k < n; k++) begin
      col = k % DIM;
      row = (k / DIM) % DIM;
      ch  = k / (DIM * DIM);
      if (k == oob_at) begin
        wr(DIM, 0, 0, 64'hDEAD, 1'b0, "wr_oob_ack");
        chk("idx_err_set", 64'(bus.idx_err), 64'd1);
      end
      if (k == rd_at) begin
        bus.rd_req = 1'b1;
        bus.rd_col = 16'(col);
        bus.rd_row = 16'(row);
        bus.rd_ch  = 16'(ch);
      end
      wr(col, row, ch, 64'(k), 1'b1, "fill_wr_ack");
      if (k == rd_at) begin
        chk("rd_while_filling", 64'(bus.rd_valid), 64'd0);
        bus.rd_req = 1'b0;
      end
      chk("full_edge", 64'(bus.full), 64'((n == TOTAL) && (k == n - 1)));
    end
    idle();
    if (oob_at >= 0) chk("idx_err_sticky", 64'(bus.idx_err), 64'd1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    cyc();
    chk("rst_wr_ack", 64'(bus.wr_ack), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_rd_data", bus.rd_data, 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
    chk("rst_idx_err", 64'(bus.idx_err), 64'd0);
  endtask

  task automatic test_fill();
    fill(TOTAL, -1, -1);
    cyc();
    chk("full_hold", 64'(bus.full), 64'd1);
    chk("ack_pulse", 64'(bus.wr_ack), 64'd0);
  endtask

  task automatic test_read();
    rd(3, 7, 5, 1'b1, "rd_single");
    chk("rd_single_data", bus.rd_data, 64'd3565);
    idle();
    cyc();
    chk("rd_valid_pulse", 64'(bus.rd_valid), 64'd0);
    chk("rd_data_hold", bus.rd_data, 64'd3565);
  endtask

  task automatic test_back_to_back();
    rd(0, 0, 0, 1'b1, "rd_b2b_first");
    rd(25, 25, 15, 1'b1, "rd_b2b_second");
    chk("rd_b2b_data", bus.rd_data, 64'd10815);
    idle();
    cyc();
    chk("rd_b2b_end", 64'(bus.rd_valid), 64'd0);
  endtask

  task automatic test_full_write_ignored();
    wr(0, 0, 0, 64'hFFFF, 1'b0, "wr_in_full");
    idle();
    chk("wr_in_full_idx", 64'(bus.idx_err), 64'd0);
    chk("wr_in_full_full", 64'(bus.full), 64'd1);
    rd(0, 0, 0, 1'b1, "rd_after_full_wr");
    idle();
    cyc();
  endtask

  task automatic test_rd_oob();
    rd(0, DIM, 0, 1'b0, "rd_oob");
    idle();
    chk("rd_oob_idx", 64'(bus.idx_err), 64'd1);
  endtask

  task automatic test_clear_with_write();
    bus.clear = 1'b1;
    cyc();
    idle();
    chk("clr_full", 64'(bus.full), 64'd0);
    chk("clr_idx_err", 64'(bus.idx_err), 64'd0);
    fill(500, -1, -1);
    bus.clear = 1'b1;
    wr(500 % DIM, (500 / DIM) % DIM, 0, 64'd500, 1'b0, "clr_wins_ack");
    idle();
    chk("clr_wins_full", 64'(bus.full), 64'd0);
    // Refill from zero, with a mid-fill read and a dropped out-of-range write.
    fill(TOTAL, 100, 200);
    idle();
    bus.clear = 1'b1;
    cyc();
    idle();
    chk("clr_after_oob_idx", 64'(bus.idx_err), 64'd0);
    chk("clr_after_oob_full", 64'(bus.full), 64'd0);
  endtask

  task automatic test_reset_mid_fill();
    fill(5000, -1, -1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("midrst_full", 64'(bus.full), 64'd0);
    chk("midrst_rd_data", bus.rd_data, 64'd0);
    fill(TOTAL, -1, -1);
    rd(25, 25, 15, 1'b1, "rd_after_refill");
    idle();
    cyc();
  endtask

  initial begin
    idle();
    bus.wr_col = '0; bus.wr_row = '0; bus.wr_ch = '0; bus.wr_data = '0;
    bus.rd_col = '0; bus.rd_row = '0; bus.rd_ch = '0;
    test_reset();
    test_fill();
    test_read();
    test_back_to_back();
    test_full_write_ignored();
    test_rd_oob();
    test_clear_with_write();
    test_reset_mid_fill();
    cyc();
    cyc();
    chk("reads_outstanding", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
